// File: rtl/riscv_data_mem.sv
// Data-memory responder for the LSU port: word RAM with byte-enabled writes and a
// fixed, parameterised completion latency; one transaction in flight at a time.
module riscv_data_mem #(
  parameter int DEPTH     = 1024,
  parameter int LATENCY   = 1,
  parameter     INIT_FILE = ""
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_be_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wd_i,
  output logic [31:0] mem_rd_o,
  output logic        mem_ready_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [3:0]      be_q, be_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [31:0]     wd_q, wd_d;
  logic [31:0]     rd_q, rd_d;

  logic [31:0]     ram [DEPTH];

  logic            commit;
  logic            acc_we;
  logic [3:0]      acc_be;
  logic [AW-1:0]   acc_idx;
  logic [31:0]     acc_wd;
  logic            unused_addr;

  assign unused_addr = ^{mem_addr_i[31:AW+2], mem_addr_i[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    be_d    = be_q;
    idx_d   = idx_q;
    wd_d    = wd_q;
    rd_d    = rd_q;
    commit  = 1'b0;
    // With LATENCY=1 the array is touched on the accept edge itself, so the
    // live inputs stand in for the not-yet-captured fields.
    acc_we  = (state_q == IDLE) ? mem_we_i                 : we_q;
    acc_be  = (state_q == IDLE) ? mem_be_i                 : be_q;
    acc_idx = (state_q == IDLE) ? mem_addr_i[AW+1:2]       : idx_q;
    acc_wd  = (state_q == IDLE) ? mem_wd_i                 : wd_q;
    case (state_q)
      IDLE: if (mem_req_i) begin
        we_d  = mem_we_i;
        be_d  = mem_be_i;
        idx_d = mem_addr_i[AW+1:2];
        wd_d  = mem_wd_i;
        if (LATENCY == 1) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      WAIT: if (cnt_q == 4'd0) begin
        state_d = RESP;
        commit  = 1'b1;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (commit && !acc_we) rd_d = ram[acc_idx];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      be_q    <= 4'd0;
      idx_q   <= '0;
      wd_q    <= 32'd0;
      rd_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      be_q    <= be_d;
      idx_q   <= idx_d;
      wd_q    <= wd_d;
      rd_q    <= rd_d;
    end
  end

  // RAM is not reset; a write whose commit edge lands inside reset is dropped.
  always_ff @(posedge clk_i) begin
    if (commit && acc_we && !rst_i) begin
      for (int n = 0; n < 4; n++) begin
        if (acc_be[n]) ram[acc_idx][8*n +: 8] <= acc_wd[8*n +: 8];
      end
    end
  end

  assign mem_rd_o    = rd_q;
  assign mem_ready_o = (state_q == RESP);
endmodule

// File: tb/tb_riscv_data_mem.sv
// Bench for riscv_data_mem: three instances (LATENCY 1/2/3) checked every cycle against
// a transaction-level model, plus directed literal checks.
module tb_riscv_data_mem;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req  [3];
  logic        we   [3];
  logic [3:0]  be   [3];
  logic [31:0] addr [3];
  logic [31:0] wd   [3];
  logic [31:0] rd   [3];
  logic        rdy  [3];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  bit started = 0;

  always #5 clk = ~clk;

  riscv_data_mem #(.DEPTH(1024), .LATENCY(1)) u_l1 (
    .clk_i(clk), .rst_i(rst), .mem_req_i(req[0]), .mem_we_i(we[0]), .mem_be_i(be[0]),
    .mem_addr_i(addr[0]), .mem_wd_i(wd[0]), .mem_rd_o(rd[0]), .mem_ready_o(rdy[0]));
  riscv_data_mem #(.DEPTH(1024), .LATENCY(2)) u_l2 (
    .clk_i(clk), .rst_i(rst), .mem_req_i(req[1]), .mem_we_i(we[1]), .mem_be_i(be[1]),
    .mem_addr_i(addr[1]), .mem_wd_i(wd[1]), .mem_rd_o(rd[1]), .mem_ready_o(rdy[1]));
  riscv_data_mem #(.DEPTH(1024), .LATENCY(3)) u_l3 (
    .clk_i(clk), .rst_i(rst), .mem_req_i(req[2]), .mem_we_i(we[2]), .mem_be_i(be[2]),
    .mem_addr_i(addr[2]), .mem_wd_i(wd[2]), .mem_rd_o(rd[2]), .mem_ready_o(rdy[2]));

  // Model: a transaction accepted at edge e commits at edge e+L-1, ready is high in
  // the cycle after that, and the next accept is possible from edge e+L+1.
  int          lat [3] = '{1, 2, 3};
  bit [31:0]   mm [3][1024];
  bit          kn [3][1024];
  logic [31:0] exp_rd  [3];
  logic        exp_rdy [3];
  bit          rd_known [3];
  int          free_e [3];
  int          commit_e [3];
  bit          c_we [3];
  bit [3:0]    c_be [3];
  int          c_idx [3];
  bit [31:0]   c_wd [3];
  int          e = 0;

  initial forever @(posedge clk) cyc++;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        exp_rdy[k] = 0; exp_rd[k] = 0; rd_known[k] = 1;
        free_e[k] = 0; commit_e[k] = -1;
      end
    end else begin
      e++;
      for (int k = 0; k < 3; k++) begin
        exp_rdy[k] = 0;
        if (e >= free_e[k] && req[k] === 1'b1) begin
          c_we[k] = we[k]; c_be[k] = be[k]; c_wd[k] = wd[k];
          c_idx[k] = int'((addr[k] / 4) % 1024);
          commit_e[k] = e + lat[k] - 1;
          free_e[k]   = e + lat[k] + 1;
        end
        if (e == commit_e[k]) begin
          exp_rdy[k] = 1;
          if (c_we[k]) begin
            for (int n = 0; n < 4; n++)
              if (c_be[k][n]) mm[k][c_idx[k]][8*n +: 8] = c_wd[k][8*n +: 8];
            if (c_be[k] == 4'hF) kn[k][c_idx[k]] = 1;
          end else begin
            exp_rd[k]   = mm[k][c_idx[k]];
            rd_known[k] = kn[k][c_idx[k]];
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (started && !rst) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("model_ready[%0d]", k), 32'(rdy[k]), 32'(exp_rdy[k]));
        if (rd_known[k]) chk($sformatf("model_rd[%0d]", k), rd[k], exp_rd[k]);
      end
    end
  end

  task automatic txn(input int k, input bit w, input logic [3:0] b, input logic [31:0] a,
                     input logic [31:0] d, output logic [31:0] r);
    bit got;
    got = 0;
    r = 32'hx;
    @(posedge clk); #2;
    req[k] = 1; we[k] = w; be[k] = b; addr[k] = a; wd[k] = d;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (rdy[k]) begin got = 1; r = rd[k]; end
    end
    @(posedge clk); #2;
    req[k] = 0; we[k] = 0; be[k] = 4'hF; addr[k] = 32'hFFFF_FFFC; wd[k] = 32'h0;
    if (!got) chk("txn_timeout", 32'd0, 32'd1);
  endtask

  logic [31:0] r;
  int c1, c2;
  bit got;

  initial begin
    for (int k = 0; k < 3; k++) begin
      req[k] = 0; we[k] = 0; be[k] = 0; addr[k] = 0; wd[k] = 0;
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("reset_ready", 32'(rdy[k]), 32'd0);
      chk("reset_rd", rd[k], 32'd0);
    end
    repeat (2) @(posedge clk);
    #3 rst = 0;
    started = 1;

    // LATENCY=1 write then read
    txn(0, 1, 4'hF, 32'h10, 32'hDEADBEEF, r);
    txn(0, 0, 4'h0, 32'h10, 32'h0, r);
    chk("l1_read", r, 32'hDEADBEEF);

    // byte enables
    txn(0, 1, 4'hF, 32'h20, 32'h11223344, r);
    txn(0, 1, 4'b0010, 32'h20, 32'h55555555, r);
    txn(0, 0, 4'hF, 32'h20, 32'h0, r);
    chk("be_0010", r, 32'h11225544);
    txn(0, 1, 4'b0000, 32'h20, 32'hFFFFFFFF, r);
    txn(0, 0, 4'h0, 32'h20, 32'h0, r);
    chk("be_0000", r, 32'h11225544);

    // aliasing
    txn(0, 1, 4'hF, 32'h1000, 32'hCAFEF00D, r);
    txn(0, 0, 4'h0, 32'h0000, 32'h0, r);
    chk("alias_0", r, 32'hCAFEF00D);
    txn(0, 0, 4'h0, 32'h0003, 32'h0, r);
    chk("alias_3", r, 32'hCAFEF00D);

    // LATENCY=3 timing with request dropped after accept
    txn(2, 1, 4'hF, 32'h40, 32'h0BADF00D, r);
    @(posedge clk); #2;
    req[2] = 1; we[2] = 0; addr[2] = 32'h40;
    @(negedge clk);
    chk("l3_T", 32'(rdy[2]), 32'd0);
    @(posedge clk); #2;
    req[2] = 0; addr[2] = 32'h10; we[2] = 1;
    @(negedge clk); chk("l3_T1", 32'(rdy[2]), 32'd0);
    @(negedge clk); chk("l3_T2", 32'(rdy[2]), 32'd0);
    @(negedge clk); chk("l3_T3", 32'(rdy[2]), 32'd1);
    chk("l3_rd", rd[2], 32'h0BADF00D);
    @(negedge clk); chk("l3_T4", 32'(rdy[2]), 32'd0);
    we[2] = 0;

    // async reset during WAIT of a write
    @(posedge clk); #2;
    req[2] = 1; we[2] = 1; be[2] = 4'hF; addr[2] = 32'h40; wd[2] = 32'h12345678;
    @(posedge clk); #3;
    req[2] = 0; we[2] = 0;
    rst = 1;
    #1;
    chk("rst_async_ready", 32'(rdy[2]), 32'd0);
    chk("rst_async_rd", rd[2], 32'd0);
    chk("rst_async_rd_l1", rd[0], 32'd0);
    @(negedge clk);
    @(posedge clk); #2;
    rst = 0;
    txn(2, 0, 4'h0, 32'h40, 32'h0, r);
    chk("rst_dropped_write", r, 32'h0BADF00D);

    // LATENCY=2 back-to-back with request held
    txn(1, 1, 4'hF, 32'h80, 32'hA5A5A5A5, r);
    txn(1, 1, 4'hF, 32'h84, 32'h5A5A1234, r);
    @(posedge clk); #2;
    req[1] = 1; we[1] = 0; addr[1] = 32'h80;
    got = 0; c1 = 0; c2 = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rdy[1]) begin got = 1; c1 = cyc; chk("b2b_rd0", rd[1], 32'hA5A5A5A5); end
    end
    if (!got) chk("b2b_timeout0", 32'd0, 32'd1);
    @(posedge clk); #2;
    addr[1] = 32'h84;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rdy[1]) begin got = 1; c2 = cyc; chk("b2b_rd1", rd[1], 32'h5A5A1234); end
    end
    if (!got) chk("b2b_timeout1", 32'd0, 32'd1);
    chk("b2b_spacing", 32'(c2 - c1), 32'd3);
    @(posedge clk); #2;
    req[1] = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
